// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the integer-to-float converter and
// the floating-point comparator that consumes its results.
package fp_pkg;

    // IEEE 754 single-precision field layout
    localparam int FP_WIDTH   = 32;
    localparam int EXP_WIDTH  = 8;
    localparam int FRAC_WIDTH = 23;
    localparam int EXP_BIAS   = 127;
    localparam int SIGN_BIT   = FP_WIDTH - 1;

    // Exponent of a value whose leading one sits at bit 31 of the magnitude
    localparam logic [EXP_WIDTH-1:0] EXP_INT_MSB = EXP_WIDTH'(EXP_BIAS + 31);

    // Zero always converts to positive zero
    localparam logic [FP_WIDTH-1:0] POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } conv_state_e;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [FRAC_WIDTH-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_round_nearest_even.sv
// Round-to-nearest-even for a 23-bit fraction given guard and sticky bits.
// A carry out of the fraction bumps the exponent; the fraction then wraps to
// zero, which is exactly the next power of two.
module fp_round_nearest_even
    import fp_pkg::*;
(
    input  logic [FRAC_WIDTH-1:0] mant_i,
    input  logic                  guard_i,
    input  logic                  sticky_i,
    input  logic [EXP_WIDTH-1:0]  exp_i,
    output logic [FRAC_WIDTH-1:0] mant_o,
    output logic [EXP_WIDTH-1:0]  exp_o
);

    logic                round_up;
    logic [FRAC_WIDTH:0] mant_sum;

    // Round up above the halfway point, or at a tie when the fraction is odd
    always_comb begin
        round_up = guard_i & (sticky_i | mant_i[0]);
        mant_sum = {1'b0, mant_i} + (FRAC_WIDTH + 1)'(round_up);
        mant_o   = mant_sum[FRAC_WIDTH-1:0];
        exp_o    = exp_i + EXP_WIDTH'(mant_sum[FRAC_WIDTH]);
    end

endmodule

// File: rtl/int_to_float_converter.sv
// Converts a signed 32-bit integer to IEEE 754 single precision. The
// magnitude is normalised one bit per cycle, then rounded to nearest-even.
// Ready/valid handshakes on both sides; all outputs come straight from flops.
module int_to_float_converter
    import fp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    conv_state_e           state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      result_q;
    logic                  sign_q;
    logic [WIDTH-1:0]      mag_q;
    logic [EXP_WIDTH-1:0]  exp_q;

    logic                  accept;
    logic                  in_is_zero;
    logic [WIDTH-1:0]      in_mag;
    logic [FRAC_WIDTH-1:0] rnd_mant;
    logic [EXP_WIDTH-1:0]  rnd_exp;

    // Operand acceptance and magnitude; negating 0x80000000 wraps back to
    // itself, which is the correct unsigned magnitude 2^31
    always_comb begin
        accept     = (state_q == IDLE) && in_valid && in_ready_q;
        in_is_zero = (in_data == '0);
        in_mag     = in_data[WIDTH-1] ? (~in_data + 1'b1) : in_data;
    end

    fp_round_nearest_even u_round (
        .mant_i   (mag_q[WIDTH-2 -: FRAC_WIDTH]),
        .guard_i  (mag_q[WIDTH-FRAC_WIDTH-2]),
        .sticky_i (|mag_q[WIDTH-FRAC_WIDTH-3:0]),
        .exp_i    (exp_q),
        .mant_o   (rnd_mant),
        .exp_o    (rnd_exp)
    );

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    // NOTE: defaults at the top of each combinational block prevent latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = in_is_zero ? DONE : NORM;
            NORM:  if (mag_q[WIDTH-1]) state_d = ROUND;
            ROUND: state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs follow the upcoming state so they can be registered
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Handshake flops and datapath: capture, shift-normalise, round
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= POS_ZERO;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            exp_q       <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sign_q <= in_data[WIDTH-1];
                        mag_q  <= in_mag;
                        exp_q  <= EXP_INT_MSB;
                        if (in_is_zero) begin
                            result_q <= POS_ZERO;
                        end
                    end
                end
                NORM: begin
                    if (!mag_q[WIDTH-1]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 1'b1;
                    end
                end
                ROUND: begin
                    result_q <= {sign_q, rnd_exp, rnd_mant};
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;

endmodule

// File: tb/tb_int_to_float_converter.sv
// Self-checking bench for int_to_float_converter: directed corner values,
// back-pressure, mid-conversion reset and randomised operands checked
// against an independent reference conversion and an ordering check.
module tb_int_to_float_converter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int unsigned n_vectors     = 0;
    int unsigned n_miscompares = 0;
    logic [31:0] sb_q[$];

    int_to_float_converter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference conversion: locate the leading one, then round the bits
    // below the 24-bit significand window to nearest-even
    function automatic logic [31:0] ref_conv(input logic [31:0] v);
        logic        s;
        logic [31:0] m;
        logic [63:0] q, rem, half;
        int          p, sh, e;
        if (v == 32'd0) return 32'd0;
        s = v[31];
        m = s ? (~v + 32'd1) : v;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        e = 127 + p;
        if (p <= 23) begin
            q = 64'(m) << (23 - p);
        end else begin
            sh   = p - 23;
            q    = 64'(m) >> sh;
            rem  = 64'(m) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {s, 8'(e), q[22:0]};
    endfunction

    function automatic int lat_of(input logic [31:0] v);
        logic [31:0] m;
        int          lz;
        if (v == 32'd0) return 1;
        m  = v[31] ? (~v + 32'd1) : v;
        lz = 0;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) break;
            lz++;
        end
        return lz + 3;
    endfunction

    // Total-order key for non-NaN floats, as the comparator sees them
    function automatic logic [31:0] fkey(input logic [31:0] b);
        return b[31] ? ~b : (b | 32'h8000_0000);
    endfunction

    // Drive one operand, push its expected result, then wait for the DUT's
    // output, pop and compare. hold > 0 applies back-pressure for that many
    // cycles while also offering a second operand that must be refused.
    task automatic convert(input logic [31:0] v, input logic [31:0] exp_res,
                           input int hold, output logic [31:0] got);
        int          k;
        logic [31:0] held;
        got = 'x;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back(exp_res);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
            k++;
        end while (!out_valid && k < 40);
        if (!out_valid) begin
            check("output_timeout", 32'(out_valid), 32'd1);
            void'(sb_q.pop_front());
            return;
        end
        check("latency", 32'(k), 32'(lat_of(v)));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        got = out_result;
        check("result", out_result, sb_q.pop_front());
        if (hold > 0) begin
            held     = out_result;
            in_valid = 1'b1;
            in_data  = 32'd7;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_result", out_result, held);
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] got, nxt, v;
        int          sh;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_result", out_result, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Directed values
        convert(32'd1,         32'h3F80_0000, 0, got);
        convert(32'hFFFF_FFFF, 32'hBF80_0000, 0, got);
        convert(32'd0,         32'h0000_0000, 0, got);
        convert(32'h8000_0000, 32'hCF00_0000, 0, got);
        convert(32'h0100_0001, 32'h4B80_0000, 0, got);
        convert(32'h0100_0003, 32'h4B80_0002, 0, got);
        convert(32'h7FFF_FFFF, 32'h4F00_0000, 0, got);

        // Back-pressure with a refused second operand
        convert(32'd12345, 32'h4640_E400, 10, got);

        // Reset during normalisation discards the conversion
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        sb_q.push_back(32'h3F80_0000);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sb_q.delete();
        check("midreset_valid", 32'(out_valid), 32'd0);
        check("midreset_result", out_result, 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_release_in_ready", 32'(in_ready), 32'd1);
        convert(32'd5, 32'h40A0_0000, 0, got);

        // Random operands of varied magnitude, plus ordering against v+1
        for (int n = 0; n < 2000; n++) begin
            sh = $urandom_range(0, 31);
            v  = 32'($urandom) >> sh;
            if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
            convert(v, ref_conv(v), 0, got);
            if (v != 32'h7FFF_FFFF) begin
                nxt = ref_conv(v + 32'd1);
                check("order_le", 32'(fkey(got) <= fkey(nxt)), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
